// File: rtl/hz_timer_if.sv
// Control and status bundle between a run-control source and the hz_timer_ctrl rate divider.
interface hz_timer_if #(
    parameter int p_DIV_W = 32,
    parameter int p_REP_W = 16
);
    logic               i_Load;
    logic [p_DIV_W-1:0] i_Div;
    logic [p_REP_W-1:0] i_Reps;
    logic               i_Mode;
    logic               i_Start;
    logic               i_Stop;
    logic               o_Tick;
    logic               o_Toggle;
    logic               o_Done;
    logic               o_Busy;
    logic               o_Err;
    logic [p_DIV_W-1:0] o_Count;

    modport master (
        output i_Load, i_Div, i_Reps, i_Mode, i_Start, i_Stop,
        input  o_Tick, o_Toggle, o_Done, o_Busy, o_Err, o_Count
    );

    modport slave (
        input  i_Load, i_Div, i_Reps, i_Mode, i_Start, i_Stop,
        output o_Tick, o_Toggle, o_Done, o_Busy, o_Err, o_Count
    );
endinterface

// File: rtl/hz_timer_ctrl.sv
// Divide-by-N tick/toggle generator with load/start/stop run control,
// periodic or burst (N periods then stop) operation, pause/resume and abort.
module hz_timer_ctrl #(
    parameter int p_DIV_W = 32,
    parameter int p_REP_W = 16
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    hz_timer_if.slave   bus
);

    // state  | meaning
    // IDLE   | configured or not, waiting for start; loads accepted here only
    // RUN    | counting toward terminal count, emitting ticks
    // HOLD   | paused, count and period count frozen
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10
    } state_t;

    localparam logic [p_DIV_W-1:0] c_DIV_ONE = {{(p_DIV_W-1){1'b0}}, 1'b1};
    localparam logic [p_REP_W-1:0] c_REP_ONE = {{(p_REP_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_next;
    logic [p_DIV_W-1:0] r_Div;
    logic [p_DIV_W-1:0] r_Count;
    logic [p_DIV_W-1:0] w_div_eff;
    logic [p_REP_W-1:0] r_Reps;
    logic [p_REP_W-1:0] r_Per;
    logic [p_REP_W-1:0] w_per_inc;
    logic [p_REP_W-1:0] w_reps_eff;
    logic               r_Mode;
    logic               r_Tick;
    logic               r_Toggle;
    logic               r_Done;
    logic               r_Err;
    logic               w_busy;
    logic               w_load_ok;
    logic               w_start_ok;
    logic               w_tc;
    logic               w_last;

    // A start on the same edge as a valid load must see the new divisor.
    always_comb begin
        w_load_ok  = bus.i_Load && (bus.i_Div != '0);
        w_div_eff  = w_load_ok ? bus.i_Div : r_Div;
        w_start_ok = bus.i_Start && !bus.i_Stop && (w_div_eff != '0);
        w_tc       = (r_Count == (r_Div - c_DIV_ONE));
        w_per_inc  = r_Per + c_REP_ONE;
        w_reps_eff = (r_Reps == '0) ? c_REP_ONE : r_Reps;
        w_last     = r_Mode && (w_per_inc == w_reps_eff);
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Burst completion on a terminal edge takes priority over a pause request.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start_ok) w_next = S_RUN;
            S_RUN: begin
                if (w_tc && w_last) begin
                    w_next = S_IDLE;
                end else if (bus.i_Stop) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.i_Stop) begin
                    w_next = S_IDLE;
                end else if (bus.i_Start) begin
                    w_next = S_RUN;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_Div    <= '0;
            r_Reps   <= '0;
            r_Mode   <= 1'b0;
            r_Count  <= '0;
            r_Per    <= '0;
            r_Tick   <= 1'b0;
            r_Toggle <= 1'b0;
            r_Done   <= 1'b0;
            r_Err    <= 1'b0;
        end else begin
            r_Tick <= 1'b0;
            r_Done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_Load) begin
                        if (bus.i_Div == '0) begin
                            r_Err <= 1'b1;
                        end else begin
                            r_Div  <= bus.i_Div;
                            r_Reps <= bus.i_Reps;
                            r_Mode <= bus.i_Mode;
                            r_Err  <= 1'b0;
                        end
                    end
                    if (w_start_ok) begin
                        r_Count  <= '0;
                        r_Per    <= '0;
                        r_Toggle <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_tc) begin
                        r_Count  <= '0;
                        r_Tick   <= 1'b1;
                        r_Toggle <= ~r_Toggle;
                        r_Per    <= w_per_inc;
                        r_Done   <= w_last;
                    end else if (!bus.i_Stop) begin
                        r_Count <= r_Count + c_DIV_ONE;
                    end
                end
                S_HOLD: begin
                    if (bus.i_Stop) begin
                        r_Count  <= '0;
                        r_Toggle <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_Tick   = r_Tick;
    assign bus.o_Toggle = r_Toggle;
    assign bus.o_Done   = r_Done;
    assign bus.o_Busy   = w_busy;
    assign bus.o_Err    = r_Err;
    assign bus.o_Count  = r_Count;

endmodule

// File: tb/tb_hz_timer_ctrl.sv
// Scoreboard bench for hz_timer_ctrl: a driver pushes per-edge expectations from an
// elapsed-time reference model, a negedge monitor pops and compares them.
module tb_hz_timer_ctrl;
    localparam int DW = 32;
    localparam int RW = 16;

    logic i_CLK = 1'b0;
    logic i_RST = 1'b1;

    hz_timer_if #(.p_DIV_W(DW), .p_REP_W(RW)) bus ();

    hz_timer_ctrl #(.p_DIV_W(DW), .p_REP_W(RW)) dut (
        .i_CLK (i_CLK),
        .i_RST (i_RST),
        .bus   (bus)
    );

    always #5 i_CLK = ~i_CLK;

    typedef struct {
        int          cyc;
        logic [31:0] cnt;
        bit          busy;
        bit          err;
        bit          tog;
        bit          tick;
        bit          done;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_ticks = 0;
    int   n_done = 0;

    // reference model: elapsed running clocks since start, ticks = elapsed / div
    int      m_st;
    longint  m_div;
    longint  m_reps;
    bit      m_mode;
    bit      m_err;
    longint  m_el;
    bit      m_tog;

    always @(posedge i_CLK) cyc <= cyc + 1;

    task automatic chk(string name, longint unsigned act, longint unsigned exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp_v);
    endtask

    always @(negedge i_CLK) begin
        if (!i_RST) begin
            if (bus.o_Tick) n_ticks++;
            if (bus.o_Done) n_done++;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                chk("lost_entry", longint'(q[0].cyc), longint'(cyc));
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("count",  longint'(bus.o_Count),  longint'(e.cnt));
                chk("busy",   longint'(bus.o_Busy),   longint'(e.busy));
                chk("err",    longint'(bus.o_Err),    longint'(e.err));
                chk("toggle", longint'(bus.o_Toggle), longint'(e.tog));
                chk("tick",   longint'(bus.o_Tick),   longint'(e.tick));
                chk("done",   longint'(bus.o_Done),   longint'(e.done));
            end
        end
    end

    task automatic model_reset();
        m_st = 0; m_div = 0; m_reps = 0; m_mode = 0; m_err = 0; m_el = 0; m_tog = 0;
    endtask

    task automatic step(bit ld, int unsigned dv, int unsigned rp, bit md, bit st, bit sp);
        exp_t e;
        @(negedge i_CLK);
        bus.i_Load  = ld;
        bus.i_Div   = dv;
        bus.i_Reps  = rp[15:0];
        bus.i_Mode  = md;
        bus.i_Start = st;
        bus.i_Stop  = sp;
        e.tick = 0;
        e.done = 0;
        case (m_st)
            0: begin
                if (ld) begin
                    if (dv == 0) m_err = 1;
                    else begin
                        m_div = dv; m_reps = rp & 32'hFFFF; m_mode = md; m_err = 0;
                    end
                end
                if (st && !sp && m_div != 0) begin
                    m_st = 1; m_el = 0; m_tog = 0;
                end
            end
            1: begin
                if ((m_el + 1) % m_div == 0) begin
                    m_el++;
                    m_tog = !m_tog;
                    e.tick = 1;
                    if (m_mode && (m_el / m_div) == ((m_reps == 0) ? 1 : m_reps)) begin
                        e.done = 1;
                        m_st = 0;
                    end else if (sp) m_st = 2;
                end else if (sp) m_st = 2;
                else m_el++;
            end
            default: begin
                if (sp) begin
                    m_st = 0; m_tog = 0;
                end else if (st) m_st = 1;
            end
        endcase
        e.cyc  = cyc + 1;
        e.cnt  = (m_st == 0) ? 32'd0 : 32'(m_el % m_div);
        e.busy = (m_st != 0);
        e.err  = m_err;
        e.tog  = m_tog;
        q.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_tick"},   longint'(bus.o_Tick),   0);
        chk({tag, "_toggle"}, longint'(bus.o_Toggle), 0);
        chk({tag, "_done"},   longint'(bus.o_Done),   0);
        chk({tag, "_busy"},   longint'(bus.o_Busy),   0);
        chk({tag, "_err"},    longint'(bus.o_Err),    0);
        chk({tag, "_count"},  longint'(bus.o_Count),  0);
    endtask

    task automatic do_reset();
        @(negedge i_CLK);
        #2;
        i_RST = 1'b1;
        #1;
        check_zero("reset");
        q.delete();
        model_reset();
        bus.i_Load = 0; bus.i_Div = 0; bus.i_Reps = 0;
        bus.i_Mode = 0; bus.i_Start = 0; bus.i_Stop = 0;
        @(negedge i_CLK);
        i_RST = 1'b0;
    endtask

    initial begin
        int snap_t, snap_d;
        bus.i_Load = 0; bus.i_Div = 0; bus.i_Reps = 0;
        bus.i_Mode = 0; bus.i_Start = 0; bus.i_Stop = 0;
        model_reset();
        repeat (2) @(negedge i_CLK);
        check_zero("por");
        i_RST = 1'b0;
        idle(2);

        // periodic divide-by-5: 8 ticks in 40 clocks, stop on the 8th terminal edge
        snap_t = n_ticks;
        step(1, 5, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        idle(39);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        idle(2);
        chk("periodic_ticks", longint'(n_ticks - snap_t), 8);

        // reset mid-run, then start with cleared divisor is ignored
        step(1, 3, 0, 0, 1, 0);
        idle(4);
        do_reset();
        step(0, 0, 0, 0, 1, 0);
        idle(2);

        // burst of 4, then burst with reps 0 behaving as 1
        snap_t = n_ticks;
        snap_d = n_done;
        step(1, 3, 4, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        idle(15);
        step(1, 3, 0, 1, 1, 0);
        idle(6);
        chk("burst_ticks", longint'(n_ticks - snap_t), 5);
        chk("burst_done",  longint'(n_done - snap_d), 2);

        // pause at count 6 for 20 clocks, resume, then stop twice
        step(1, 10, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        idle(6);
        step(0, 0, 0, 0, 0, 1);
        idle(20);
        step(0, 0, 0, 0, 1, 0);
        idle(5);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        idle(2);

        // error load, divide-by-1, load during run, start+stop together
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        idle(2);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        idle(4);
        step(1, 7, 2, 1, 0, 0);
        idle(3);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1);
        idle(3);

        // stop on the final burst terminal edge, then on the first one
        step(1, 4, 2, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        idle(7);
        step(0, 0, 0, 0, 0, 1);
        idle(2);
        step(0, 0, 0, 0, 1, 0);
        idle(3);
        step(0, 0, 0, 0, 0, 1);
        idle(3);
        step(0, 0, 0, 0, 1, 0);
        idle(6);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        idle(2);

        // randomized control traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 16) == 0, $urandom_range(0, 6), $urandom_range(0, 3),
                 $urandom_range(0, 1) == 1, ($urandom % 6) == 0, ($urandom % 10) == 0);
        end
        idle(3);
        @(negedge i_CLK);
        #1;
        chk("queue_drained", longint'(q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
